isp_awb: RTL and testbench



---
 rtl/isp_awb_pkg.sv | 18 +
 rtl/isp_awb_div.sv | 86 ++++++++
 rtl/isp_awb.sv | 208 ++++++++++++++++++++
 tb/tb_isp_awb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_awb_pkg.sv
// Shared definitions for the gray-world auto-white-balance stage.
//   GAIN_*      : Q3.7 unsigned gain format (GAIN_ONE = 1.0, GAIN_MAX = 4.0)
//   awb_state_e : gain-computation FSM states
package isp_awb_pkg;

    localparam int GAIN_W    = 10;
    localparam int GAIN_FRAC = 7;
    localparam int GAIN_ONE  = 128;
    localparam int GAIN_MAX  = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_R = 2'd1,
        ST_DIV_B = 2'd2,
        ST_DONE  = 2'd3
    } awb_state_e;

endpackage

// File: rtl/isp_awb_div.sv
// Sequential restoring divider producing a Q3.7 gain.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : load operands (also aborts a divide in progress)
//   dividend_i  : green sum scaled by 128
//   divisor_i   : red or blue sum
//   busy_o      : divide in progress
//   done_o      : one-cycle pulse, quot_o valid from this cycle on
//   quot_o      : floor(dividend/divisor), or GAIN_MAX when the ratio is >= 4.0
// Timing: 1 load + GAIN_W iterations + 1 writeback cycle.
module isp_awb_div
    import isp_awb_pkg::*;
#(
    parameter int SUM_W = 26
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [SUM_W+GAIN_FRAC-1:0] dividend_i,
    input  logic [SUM_W-1:0]           divisor_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [GAIN_W-1:0]          quot_o
);

    logic [SUM_W-1:0]  rem_q;
    logic [GAIN_W-1:0] lo_q;
    logic [SUM_W-1:0]  dvs_q;
    logic [GAIN_W-1:0] q_q;
    logic [GAIN_W-1:0] quot_q;
    logic [3:0]        cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              clamp_q;

    // Shift in the next dividend bit. The carry-out bit means the trial is
    // certainly >= divisor, so it takes part in the compare.
    logic [SUM_W:0] trial;
    logic           ge;
    assign trial = {rem_q, lo_q[GAIN_W-1]};
    assign ge    = trial[SUM_W] | (trial[SUM_W-1:0] >= dvs_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                // Only GAIN_W quotient bits are produced, so the upper dividend
                // bits seed the remainder directly; when not clamped they are
                // already below the divisor.
                rem_q   <= SUM_W'(dividend_i[SUM_W+GAIN_FRAC-1:GAIN_W]);
                lo_q    <= dividend_i[GAIN_W-1:0];
                dvs_q   <= divisor_i;
                clamp_q <= (divisor_i == '0) ||
                           ({2'b00, dividend_i} >= {divisor_i, {(GAIN_FRAC+2){1'b0}}});
                q_q     <= '0;
                cnt_q   <= 4'(GAIN_W);
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q != 4'd0) begin
                    rem_q <= ge ? (trial[SUM_W-1:0] - dvs_q) : trial[SUM_W-1:0];
                    lo_q  <= {lo_q[GAIN_W-2:0], 1'b0};
                    q_q   <= {q_q[GAIN_W-2:0], ge};
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    quot_q <= clamp_q ? GAIN_W'(GAIN_MAX) : q_q;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = quot_q;

endmodule

// File: rtl/isp_awb.sv
// Gray-world auto-white-balance. Per-frame RGB sums (clipped pixels excluded)
// are turned into red/blue gains relative to green during vertical blank and
// applied to the next frame.
//   clk, reset_n               : pixel clock, asynchronous active-low reset
//   in_vsync/in_hsync/in_den   : input syncs; in_vsync rising edge = frame end
//   in_data_R/G/B              : demosaiced pixel
//   awb_en                     : 1 = apply gains, 0 = unity (statistics still run)
//   out_vsync/out_hsync/out_den: syncs delayed 2 cycles
//   out_data_R/G/B             : balanced pixel, 2-cycle latency
//   gain_R/gain_B              : active Q3.7 gains
module isp_awb
    import isp_awb_pkg::*;
#(
    parameter int source_h = 512,
    parameter int source_v = 512,
    parameter int SUM_W    = 8 + $clog2(source_h * source_v)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_den,
    input  logic [7:0]        in_data_R,
    input  logic [7:0]        in_data_G,
    input  logic [7:0]        in_data_B,
    input  logic              awb_en,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_den,
    output logic [7:0]        out_data_R,
    output logic [7:0]        out_data_G,
    output logic [7:0]        out_data_B,
    output logic [GAIN_W-1:0] gain_R,
    output logic [GAIN_W-1:0] gain_B
);

    // Channel index: 0 = R, 1 = G, 2 = B
    logic [7:0]        in_px  [3];
    logic [7:0]        out_px [3];
    logic [GAIN_W-1:0] g_sel  [3];

    assign in_px[0] = in_data_R;
    assign in_px[1] = in_data_G;
    assign in_px[2] = in_data_B;

    logic [2:0] sync1_q, sync2_q;   // {vsync, hsync, den}
    logic       vs_rise, vs_fall;

    // sync1_q[2] is in_vsync one cycle ago, which doubles as the edge detector.
    assign vs_rise = in_vsync & ~sync1_q[2];
    assign vs_fall = ~in_vsync & sync1_q[2];

    // ---------------- statistics ----------------
    logic             px_valid;
    logic [SUM_W-1:0] sum_q [3];
    logic [SUM_W-1:0] snap_g_q, snap_b_q;

    assign px_valid = in_den && (in_data_R != 8'hFF) && (in_data_G != 8'hFF)
                             && (in_data_B != 8'hFF);

    // The frame-end pixel (if any) belongs to the new frame. Red needs no
    // snapshot: the divider captures it on the frame-end edge itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 3; c++) sum_q[c] <= '0;
            snap_g_q <= '0;
            snap_b_q <= '0;
        end else if (vs_rise) begin
            snap_g_q <= sum_q[1];
            snap_b_q <= sum_q[2];
            for (int c = 0; c < 3; c++) sum_q[c] <= px_valid ? SUM_W'(in_px[c]) : '0;
        end else if (px_valid) begin
            for (int c = 0; c < 3; c++) sum_q[c] <= sum_q[c] + SUM_W'(in_px[c]);
        end
    end

    // ---------------- gain FSM ----------------
    awb_state_e        state_q, state_d;
    logic              div_start, div_live, cap_r, load_new;
    logic              div_busy, div_done;
    logic [GAIN_W-1:0] div_quot;
    logic [GAIN_W-1:0] tmp_r_q, new_r_q, new_b_q, gain_r_q, gain_b_q;
    logic              pending_q;

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_live  = 1'b0;
        cap_r     = 1'b0;
        load_new  = 1'b0;
        if (vs_rise) begin
            // A frame end always (re)starts from fresh sums, abandoning any
            // divide in flight; an empty green sum means no usable statistics.
            if (sum_q[1] != '0) begin
                state_d   = ST_DIV_R;
                div_start = 1'b1;
                div_live  = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_DIV_R: begin
                    if (div_done) begin
                        state_d   = ST_DIV_B;
                        div_start = 1'b1;
                        cap_r     = 1'b1;
                    end else if (!div_busy) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DIV_B: begin
                    if (div_done) begin
                        state_d  = ST_DONE;
                        load_new = 1'b1;
                    end else if (!div_busy) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    isp_awb_div #(.SUM_W(SUM_W)) u_div (
        .clk        (clk),
        .rst_n      (reset_n),
        .start_i    (div_start),
        .dividend_i (div_live ? {sum_q[1], {GAIN_FRAC{1'b0}}} : {snap_g_q, {GAIN_FRAC{1'b0}}}),
        .divisor_i  (div_live ? sum_q[0] : snap_b_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

    // new_r/new_b change only as a pair, so a commit never mixes two frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tmp_r_q   <= '0;
            new_r_q   <= '0;
            new_b_q   <= '0;
            pending_q <= 1'b0;
            gain_r_q  <= GAIN_W'(GAIN_ONE);
            gain_b_q  <= GAIN_W'(GAIN_ONE);
        end else begin
            state_q <= state_d;
            if (cap_r) tmp_r_q <= div_quot;
            if (vs_fall && pending_q) begin
                gain_r_q <= new_r_q;
                gain_b_q <= new_b_q;
            end
            if (load_new) begin
                new_r_q   <= tmp_r_q;
                new_b_q   <= div_quot;
                pending_q <= 1'b1;
            end else if (vs_fall) begin
                pending_q <= 1'b0;
            end
        end
    end

    // ---------------- pixel pipeline ----------------
    assign g_sel[0] = awb_en ? gain_r_q : GAIN_W'(GAIN_ONE);
    assign g_sel[1] = GAIN_W'(GAIN_ONE);
    assign g_sel[2] = awb_en ? gain_b_q : GAIN_W'(GAIN_ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {in_vsync, in_hsync, in_den};
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pix
            // Stage 1 keeps product bits [17:6]; bits below 6 cannot affect
            // (p + 64) >> 7, which equals (p[17:6] + 1) >> 1.
            logic [11:0] p_q;
            logic [7:0]  o_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    p_q <= '0;
                    o_q <= '0;
                end else begin
                    p_q <= 12'((18'(in_px[gi]) * 18'(g_sel[gi])) >> 6);
                    o_q <= (p_q >= 12'd511) ? 8'hFF : 8'((p_q + 12'd1) >> 1);
                end
            end
            assign out_px[gi] = o_q;
        end
    endgenerate

    assign out_vsync  = sync2_q[2];
    assign out_hsync  = sync2_q[1];
    assign out_den    = sync2_q[0];
    assign out_data_R = out_px[0];
    assign out_data_G = out_px[1];
    assign out_data_B = out_px[2];
    assign gain_R     = gain_r_q;
    assign gain_B     = gain_b_q;

endmodule

// File: tb/tb_isp_awb.sv
module tb_isp_awb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_vsync, in_hsync, in_den, awb_en;
    logic [7:0] in_data_R, in_data_G, in_data_B;
    logic       out_vsync, out_hsync, out_den;
    logic [7:0] out_data_R, out_data_G, out_data_B;
    logic [9:0] gain_R, gain_B;

    always #5 clk = ~clk;

    isp_awb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_vsync   (in_vsync),
        .in_hsync   (in_hsync),
        .in_den     (in_den),
        .in_data_R  (in_data_R),
        .in_data_G  (in_data_G),
        .in_data_B  (in_data_B),
        .awb_en     (awb_en),
        .out_vsync  (out_vsync),
        .out_hsync  (out_hsync),
        .out_den    (out_den),
        .out_data_R (out_data_R),
        .out_data_G (out_data_G),
        .out_data_B (out_data_B),
        .gain_R     (gain_R),
        .gain_B     (gain_B)
    );

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       den;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model state: frame sums, a job finishing 24 cycles after the
    // frame end, a pending result and the active gains.
    longint m_sum [3];
    int     m_gain_r, m_gain_b;
    int     m_job, m_ready, m_job_r, m_job_b;
    int     m_pend, m_pend_r, m_pend_b;
    logic   m_prev_vs;
    int     m_tick;
    pix_t   prev_exp;
    logic [7:0] last_r, last_g, last_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_tick, obs, exp);
        end
    endtask

    function automatic logic [7:0] sat(input int p);
        int v;
        v = (p + 64) >>> 7;
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    function automatic int awb_gain(input longint g, input longint x);
        if (x == 0 || g >= 4 * x) return 512;
        return int'((g * 128) / x);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) m_sum[c] = 0;
        m_gain_r = 128; m_gain_b = 128;
        m_job = 0; m_pend = 0; m_prev_vs = 1'b0;
        prev_exp = '0;
    endtask

    // One clock: drive inputs, predict, then check outputs after the edge.
    task automatic tick(input logic vs, input logic hs, input logic den,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pix_t e;
        pix_t obs;
        in_vsync = vs; in_hsync = hs; in_den = den;
        in_data_R = r; in_data_G = g; in_data_B = b;
        e.vs = vs; e.hs = hs; e.den = den;
        e.r = sat(int'(r) * (awb_en ? m_gain_r : 128));
        e.g = sat(int'(g) * 128);
        e.b = sat(int'(b) * (awb_en ? m_gain_b : 128));
        if (!vs && m_prev_vs && m_pend != 0) begin
            m_gain_r = m_pend_r; m_gain_b = m_pend_b; m_pend = 0;
        end
        if (vs && !m_prev_vs) begin
            if (m_sum[1] != 0) begin
                m_job   = 1;
                m_ready = m_tick + 24;
                m_job_r = awb_gain(m_sum[1], m_sum[0]);
                m_job_b = awb_gain(m_sum[1], m_sum[2]);
            end else begin
                m_job = 0;
            end
            for (int c = 0; c < 3; c++) m_sum[c] = 0;
        end else if (m_job != 0 && m_tick == m_ready) begin
            m_pend = 1; m_pend_r = m_job_r; m_pend_b = m_job_b; m_job = 0;
        end
        if (den && r != 8'hFF && g != 8'hFF && b != 8'hFF) begin
            m_sum[0] += r; m_sum[1] += g; m_sum[2] += b;
        end
        m_prev_vs = vs;
        @(posedge clk);
        #1;
        obs = {out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B};
        chk("pixel", 32'(obs), 32'(prev_exp));
        chk("gains", {12'd0, gain_R, gain_B}, {12'd0, 10'(m_gain_r), 10'(m_gain_b)});
        if (out_den) begin
            last_r = out_data_R; last_g = out_data_G; last_b = out_data_B;
        end
        prev_exp = e;
        m_tick++;
    endtask

    // 4 lines of 8 pixels. mode 0: uniform, 1: random (+ random awb_en),
    // 2: alternate clipped white and the given colour.
    task automatic lines(input int mode, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
        logic [7:0] pr, pg, pb;
        for (int l = 0; l < 4; l++) begin
            tick(0, 1, 0, 0, 0, 0);
            tick(0, 1, 0, 0, 0, 0);
            for (int p = 0; p < 8; p++) begin
                pr = r; pg = g; pb = b;
                if (mode == 1) begin
                    pr = 8'($urandom_range(0, 255));
                    pg = 8'($urandom_range(1, 255));
                    pb = 8'($urandom_range(0, 255));
                    awb_en = 1'($urandom_range(0, 1));
                end else if (mode == 2 && (p % 2) == 1) begin
                    pr = 8'hFF; pg = 8'hFF; pb = 8'hFF;
                end
                tick(0, 0, 1, pr, pg, pb);
            end
            tick(0, 0, 0, 0, 0, 0);
            tick(0, 0, 0, 0, 0, 0);
        end
        if (mode == 1) awb_en = 1'b1;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame(input int mode, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input int n);
        lines(mode, r, g, b);
        blank(n);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("reset_async_out", {5'd0, out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B}, 32'd0);
        chk("reset_async_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd128, 10'd128});
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        m_tick = 0;
        reset_n = 1'b0;
        awb_en = 1'b1;
        in_vsync = 0; in_hsync = 0; in_den = 0;
        in_data_R = 0; in_data_G = 0; in_data_B = 0;
        last_r = 0; last_g = 0; last_b = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {5'd0, out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B}, 32'd0);
        chk("reset_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd128, 10'd128});
        reset_n = 1'b1;

        // Unity
        frame(0, 100, 100, 100, 30);
        chk("unity_out", {8'd0, last_r, last_g, last_b}, {8'd0, 8'd100, 8'd100, 8'd100});
        chk("unity_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd128, 10'd128});

        // Gray world
        frame(0, 64, 128, 32, 30);
        chk("gray_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd256, 10'd512});
        frame(0, 64, 128, 32, 30);
        chk("gray_out", {8'd0, last_r, last_g, last_b}, {8'd0, 8'd128, 8'd128, 8'd128});

        // Clamp at 4.0
        frame(0, 8, 128, 128, 30);
        chk("clamp_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd512, 10'd128});
        frame(0, 8, 128, 128, 30);
        chk("clamp_out_r", {24'd0, last_r}, {24'd0, 8'd32});

        // Saturation
        frame(0, 64, 128, 64, 30);
        chk("sat_setup", {12'd0, gain_R, gain_B}, {12'd0, 10'd256, 10'd256});
        frame(0, 200, 128, 64, 30);
        chk("sat_out_r", {24'd0, last_r}, {24'd0, 8'd255});
        chk("ratio_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd81, 10'd256});

        // Zero red sum
        frame(0, 0, 100, 100, 30);
        chk("zero_r_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd512, 10'd128});

        // Clipped exclusion
        frame(2, 50, 100, 50, 30);
        chk("clip_half_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd256, 10'd256});
        frame(0, 255, 255, 255, 30);
        chk("clip_all_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd256, 10'd256});

        // Bypass
        awb_en = 1'b0;
        frame(0, 77, 100, 33, 30);
        chk("bypass_out", {8'd0, last_r, last_g, last_b}, {8'd0, 8'd77, 8'd100, 8'd33});
        chk("bypass_stats", {12'd0, gain_R, gain_B}, {12'd0, 10'd166, 10'd387});
        awb_en = 1'b1;

        // Random content
        for (int i = 0; i < 3; i++) frame(1, 0, 0, 0, 30);

        // Short blank: commit deferred to a later vsync fall
        frame(0, 100, 100, 100, 30);
        frame(0, 64, 128, 32, 10);
        chk("short_blank_hold", {12'd0, gain_R, gain_B}, {12'd0, 10'd128, 10'd128});
        frame(0, 255, 255, 255, 30);
        chk("short_blank_commit", {12'd0, gain_R, gain_B}, {12'd0, 10'd256, 10'd512});

        // Reset while dividing the blue gain
        lines(0, 32, 128, 64);
        for (int i = 0; i < 16; i++) tick(1, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("post_reset_gains", {12'd0, gain_R, gain_B}, {12'd0, 10'd128, 10'd128});
        frame(0, 64, 128, 32, 30);
        chk("post_reset_unity_out", {8'd0, last_r, last_g, last_b}, {8'd0, 8'd64, 8'd128, 8'd32});
        chk("post_reset_stats", {12'd0, gain_R, gain_B}, {12'd0, 10'd256, 10'd512});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
